// File: rtl/acc_cpu_core_if.sv
// Memory bus between acc_cpu_core (master) and its asynchronous-read single-port RAM (slave).
interface acc_cpu_core_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator core with a bounded call/return stack and halt/fault reporting.
// Optional MUL opcode enabled by defining ACC_CPU_MUL_EN.
module acc_cpu_core #(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  acc_cpu_core_if.master       mem,
  output logic                 halted,
  output logic                 fault,
  output logic [DW-1:0]        acc_out,
  output logic [AW-1:0]        pc_out
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_CALL  = 4'h8;
  localparam logic [3:0] OP_RET   = 4'h9;
  localparam logic [3:0] OP_LDI   = 4'hA;
`ifdef ACC_CPU_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'hB;
`endif
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {RESET, FETCH, EXEC, HALT} stateT;

  stateT          state, nextState;
  logic [DW-1:0]  ir, irNext;
  logic [DW-1:0]  acc, accNext;
  logic [AW-1:0]  pc, pcNext;
  logic           z, zNext;
  logic [SPW-1:0] sp, spNext;
  logic           haltedNext, faultNext;
  logic           pushEn;
  logic           accWrite;
  logic [AW-1:0]  memAddr;
  logic           memWe;
  logic [AW-1:0]  stackMem [STACK_DEPTH];
  logic [AW-1:0]  stackTop;
  logic [SPW-1:0] spDec;
  logic [3:0]     opcode;
  logic [AW-1:0]  operand;

  assign opcode   = ir[DW-1 -: 4];
  assign operand  = ir[AW-1:0];
  assign spDec    = sp - SPW'(1);
  assign stackTop = stackMem[IW'(spDec)];

  generate
    if (DW > AW + 4) begin : gIgnoredIrBits
      logic unusedIrBits;
      assign unusedIrBits = ^ir[DW-5:AW];
    end
  endgenerate

  // Next-state, datapath next values and bus controls
  always_comb begin
    nextState  = state;
    irNext     = ir;
    accNext    = acc;
    zNext      = z;
    pcNext     = pc;
    spNext     = sp;
    haltedNext = halted;
    faultNext  = fault;
    pushEn     = 1'b0;
    accWrite   = 1'b0;
    memAddr    = pc;
    memWe      = 1'b0;
    case (state)
      RESET: nextState = FETCH;
      FETCH: begin
        irNext    = mem.mem_rdata;
        pcNext    = pc + AW'(1);
        nextState = EXEC;
      end
      EXEC: begin
        memAddr   = operand;
        nextState = FETCH;
        case (opcode)
          OP_LOAD:  begin accNext = mem.mem_rdata;       accWrite = 1'b1; end
          OP_STORE: memWe = 1'b1;
          OP_ADD:   begin accNext = acc + mem.mem_rdata; accWrite = 1'b1; end
          OP_SUB:   begin accNext = acc - mem.mem_rdata; accWrite = 1'b1; end
          OP_AND:   begin accNext = acc & mem.mem_rdata; accWrite = 1'b1; end
          OP_JMP:   pcNext = operand;
          OP_JZ:    if (z) pcNext = operand;
          OP_CALL: begin
            // A full stack leaves PC untouched and stops the core
            if (sp == SPW'(STACK_DEPTH)) begin
              haltedNext = 1'b1;
              faultNext  = 1'b1;
              nextState  = HALT;
            end else begin
              pushEn = 1'b1;
              spNext = sp + SPW'(1);
              pcNext = operand;
            end
          end
          OP_RET: begin
            if (sp == '0) begin
              haltedNext = 1'b1;
              faultNext  = 1'b1;
              nextState  = HALT;
            end else begin
              pcNext = stackTop;
              spNext = spDec;
            end
          end
          OP_LDI:   begin accNext = DW'(operand);        accWrite = 1'b1; end
`ifdef ACC_CPU_MUL_EN
          OP_MUL:   begin accNext = acc * mem.mem_rdata; accWrite = 1'b1; end
`endif
          OP_HALT: begin
            haltedNext = 1'b1;
            nextState  = HALT;
          end
          default: ;
        endcase
        if (accWrite) zNext = (accNext == '0);
      end
      HALT: ;
      default: nextState = RESET;
    endcase
    // An interrupted STORE must never reach the RAM
    if (rst) memWe = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RESET;
      pc     <= AW'(RESET_PC);
      acc    <= '0;
      ir     <= '0;
      z      <= 1'b1;
      sp     <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= nextState;
      pc     <= pcNext;
      acc    <= accNext;
      ir     <= irNext;
      z      <= zNext;
      sp     <= spNext;
      halted <= haltedNext;
      fault  <= faultNext;
    end
  end

  // Return addresses; the pushed PC is already incremented by FETCH
  always_ff @(posedge clk) begin
    if (!rst && pushEn) stackMem[IW'(sp)] <= pc;
  end

  assign mem.mem_addr  = memAddr;
  assign mem.mem_wdata = acc;
  assign mem.mem_we    = memWe;
  assign acc_out       = acc;
  assign pc_out        = pc;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed self-checking bench for acc_cpu_core with a scoreboard of expected observations.
module tb_acc_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted, fault;
  logic [15:0] accOut;
  logic [7:0]  pcOut;
  logic        ramClr = 1'b0;
  logic        progWe = 1'b0;
  logic [7:0]  progAddr = '0;
  logic [15:0] progData = '0;
  logic [15:0] ram [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } expT;
  expT sbq[$];

  acc_cpu_core_if #(.DW(16), .AW(8)) bus ();

  acc_cpu_core #(.DW(16), .AW(8), .STACK_DEPTH(4), .RESET_PC(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem     (bus),
    .halted  (halted),
    .fault   (fault),
    .acc_out (accOut),
    .pc_out  (pcOut)
  );

  always #5 clk = ~clk;

  // RAM model: asynchronous read, synchronous write; program loading shares the write port
  always @(posedge clk) begin
    if (ramClr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (progWe) begin
      ram[progAddr] <= progData;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = ram[bus.mem_addr];

  task automatic pushExp(input string tag, input logic [31:0] v);
    expT e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    expT e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %0h expected none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h (cycle %0d)", e.tag, obs, e.val, cyc);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
    pushExp(tag, v);
    popCheck(obs);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic beginProg();
    @(negedge clk);
    rst = 1'b1;
    ramClr = 1'b1;
    @(negedge clk);
    ramClr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    progWe = 1'b1;
    progAddr = a;
    progData = d;
    @(negedge clk);
    progWe = 1'b0;
  endtask

  // Deassert reset mid-cycle; the current cycle is cycle 0 (state RESET)
  task automatic releaseRst();
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc = 0;
  endtask

  initial begin
    // Basic program: LDI 5; ADD 0x20; STORE 0x21; HALT
    beginProg();
    wr(8'h00, 16'hA005);
    wr(8'h01, 16'h3020);
    wr(8'h02, 16'h2021);
    wr(8'h03, 16'hF000);
    wr(8'h20, 16'h0003);
    chk("rst_we", 32'(bus.mem_we), 0);
    releaseRst();
    chk("reset_acc", 32'(accOut), 0);
    chk("reset_pc", 32'(pcOut), 0);
    chk("reset_addr", 32'(bus.mem_addr), 0);
    chk("reset_fault", 32'(fault), 0);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) step(1);
      pushExp("t1_we", 32'(c == 6));
      pushExp("t1_halted", 32'(c >= 9));
      popCheck(32'(bus.mem_we));
      popCheck(32'(halted));
      if (c == 6) begin
        chk("t1_st_addr", 32'(bus.mem_addr), 32'h21);
        chk("t1_st_data", 32'(bus.mem_wdata), 32'h0008);
      end
    end
    chk("t1_ram21", 32'(ram[8'h21]), 32'h0008);
    chk("t1_fault", 32'(fault), 0);
    chk("t1_acc", 32'(accOut), 32'h0008);
    chk("t1_pc", 32'(pcOut), 32'h04);

    // JZ taken: LDI 0; JZ 0x10
    beginProg();
    wr(8'h00, 16'hA000);
    wr(8'h01, 16'h7010);
    wr(8'h10, 16'hF000);
    releaseRst();
    step(5);
    chk("jz_taken_pc", 32'(pcOut), 32'h10);
    step(2);
    chk("jz_taken_halt", 32'(halted), 1);

    // JZ not taken: LDI 1; JZ 0x10 falls through
    beginProg();
    wr(8'h00, 16'hA001);
    wr(8'h01, 16'h7010);
    wr(8'h02, 16'hF000);
    wr(8'h10, 16'hF000);
    releaseRst();
    step(5);
    chk("jz_fall_pc", 32'(pcOut), 32'h02);
    step(2);
    chk("jz_fall_acc", 32'(accOut), 32'h0001);
    chk("jz_fall_halt", 32'(halted), 1);

    // Arithmetic: LDI 0x0F; SUB 0x20; AND 0x22; STORE 0x23; opcode C (NOP); HALT
    beginProg();
    wr(8'h00, 16'hA00F);
    wr(8'h01, 16'h4020);
    wr(8'h02, 16'h5022);
    wr(8'h03, 16'h2023);
    wr(8'h04, 16'hC0FF);
    wr(8'h05, 16'hF000);
    wr(8'h20, 16'h0010);
    wr(8'h22, 16'h00F0);
    releaseRst();
    step(5);
    chk("sub_wrap_acc", 32'(accOut), 32'hFFFF);
    step(8);
    chk("and_acc", 32'(accOut), 32'h00F0);
    chk("and_ram23", 32'(ram[8'h23]), 32'h00F0);
    chk("nop_pc", 32'(pcOut), 32'h06);
    chk("arith_halt", 32'(halted), 1);

    // Nested CALL depth 4 then 4 RETs in LIFO order
    beginProg();
    wr(8'h00, 16'h8010);
    wr(8'h01, 16'hF000);
    wr(8'h10, 16'h8020);
    wr(8'h11, 16'h9000);
    wr(8'h20, 16'h8030);
    wr(8'h21, 16'h9000);
    wr(8'h30, 16'h8040);
    wr(8'h31, 16'h9000);
    wr(8'h40, 16'h9000);
    pushExp("call1_pc", 32'h10);
    pushExp("call2_pc", 32'h20);
    pushExp("call3_pc", 32'h30);
    pushExp("call4_pc", 32'h40);
    pushExp("ret1_pc", 32'h31);
    pushExp("ret2_pc", 32'h21);
    pushExp("ret3_pc", 32'h11);
    pushExp("ret4_pc", 32'h01);
    releaseRst();
    step(3);
    popCheck(32'(pcOut));
    for (int i = 0; i < 7; i++) begin
      step(2);
      popCheck(32'(pcOut));
    end
    step(2);
    chk("nest_halt", 32'(halted), 1);
    chk("nest_fault", 32'(fault), 0);

    // Fifth nested CALL overflows the stack
    beginProg();
    wr(8'h00, 16'h8010);
    wr(8'h10, 16'h8020);
    wr(8'h20, 16'h8030);
    wr(8'h30, 16'h8040);
    wr(8'h40, 16'h8050);
    wr(8'h50, 16'hF000);
    releaseRst();
    step(10);
    chk("ovf_exec_halt", 32'(halted), 0);
    step(1);
    chk("ovf_halt", 32'(halted), 1);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_pc", 32'(pcOut), 32'h41);
    step(3);
    chk("ovf_pc_hold", 32'(pcOut), 32'h41);

    // RET with an empty stack right after reset
    beginProg();
    wr(8'h00, 16'h9000);
    releaseRst();
    for (int c = 1; c <= 4; c++) begin
      step(1);
      chk("unf_we", 32'(bus.mem_we), 0);
      chk("unf_halt", 32'(halted), 32'(c >= 3));
    end
    chk("unf_fault", 32'(fault), 1);
    chk("unf_pc", 32'(pcOut), 32'h01);

    // Reset arriving during the EXEC of a STORE
    beginProg();
    wr(8'h00, 16'hA007);
    wr(8'h01, 16'h2030);
    wr(8'h02, 16'hF000);
    releaseRst();
    step(4);
    chk("irq_store_we", 32'(bus.mem_we), 1);
    chk("irq_store_addr", 32'(bus.mem_addr), 32'h30);
    rst = 1'b1;
    #1;
    chk("irq_rst_we", 32'(bus.mem_we), 0);
    step(1);
    chk("irq_ram30", 32'(ram[8'h30]), 0);
    chk("irq_pc", 32'(pcOut), 0);
    chk("irq_addr", 32'(bus.mem_addr), 0);
    chk("irq_acc", 32'(accOut), 0);
    rst = 1'b0;
    #1;
    cyc = 0;
    step(7);
    chk("irq_rerun_halt", 32'(halted), 1);
    chk("irq_rerun_ram30", 32'(ram[8'h30]), 32'h0007);

    // MUL: 0x0100 * 0x0100 wraps to zero when enabled, NOP otherwise
    beginProg();
    wr(8'h00, 16'h1020);
    wr(8'h01, 16'hB020);
    wr(8'h02, 16'h7010);
    wr(8'h03, 16'hF000);
    wr(8'h10, 16'hF000);
    wr(8'h20, 16'h0100);
    releaseRst();
    step(5);
`ifdef ACC_CPU_MUL_EN
    chk("mul_acc", 32'(accOut), 32'h0000);
`else
    chk("mul_acc", 32'(accOut), 32'h0100);
`endif
    step(4);
`ifdef ACC_CPU_MUL_EN
    chk("mul_z_pc", 32'(pcOut), 32'h11);
`else
    chk("mul_z_pc", 32'(pcOut), 32'h04);
`endif
    chk("mul_halt", 32'(halted), 1);

    if (sbq.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
